// File: rtl/ysyx_22040175_mem_pkg.sv
// rtl/ysyx_22040175_mem_pkg.sv - shared types and constants for the instruction memory responder
package ysyx_22040175_mem_pkg;

  localparam int WORD_W = 32;
  localparam logic [31:0] DEF_BASE_ADDR = 32'h8000_0000;

  localparam logic ERR = 1'b1;
  localparam logic OK  = 1'b0;

  typedef struct packed {
    logic              err;
    logic [WORD_W-1:0] data;
  } rsp_entry_t;

endpackage

// File: rtl/ysyx_22040175_imem_resp_if.sv
// rtl/ysyx_22040175_imem_resp_if.sv - fetch request/response channel between core and memory
interface ysyx_22040175_imem_resp_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/ysyx_22040175_sync_fifo.sv
// rtl/ysyx_22040175_sync_fifo.sv - show-ahead synchronous FIFO with occupancy count
module ysyx_22040175_sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] store [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  // A full FIFO may still take a push when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = store[rd_ptr];
  assign count   = cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= din;
  end
endmodule

// File: rtl/ysyx_22040175_imem_resp.sv
// rtl/ysyx_22040175_imem_resp.sv - fixed-latency instruction fetch responder over a word array
module ysyx_22040175_imem_resp
  import ysyx_22040175_mem_pkg::*;
#(
  parameter int              ADDR_W     = 32,
  parameter int              DATA_W     = WORD_W,
  parameter int              MEM_WORDS  = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int              LATENCY    = 2,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  ysyx_22040175_imem_resp_if.slave     bus,
  input  logic                         ld_en,
  input  logic [$clog2(MEM_WORDS)-1:0] ld_idx,
  input  logic [DATA_W-1:0]            ld_data
);
  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int ENT_W = DATA_W + 1;

  logic [DATA_W-1:0] mem [MEM_WORDS];

  logic              st_valid [LATENCY];
  logic              st_err   [LATENCY];
  logic [DATA_W-1:0] st_data  [LATENCY];

  logic [ADDR_W-1:0] word_off;
  logic              req_err;
  logic              accept;
  logic              pop;
  logic              push;
  logic [CNT_W-1:0]  outstanding;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [ENT_W-1:0]  head;

  always_comb begin
    word_off = (bus.req_addr - BASE_ADDR) >> 2;
    req_err  = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr < BASE_ADDR)
            || (word_off >= ADDR_W'(MEM_WORDS));
  end

  // Everything accepted but not yet popped lives either in the pipe or in the FIFO,
  // so their sum is the outstanding count and bounds the FIFO against overflow.
  always_comb begin
    outstanding = fifo_count;
    for (int i = 0; i < LATENCY; i++) begin
      outstanding = outstanding + CNT_W'(st_valid[i]);
    end
  end

  assign bus.req_ready = !rst && (outstanding < CNT_W'(FIFO_DEPTH));
  assign accept        = bus.req_valid && bus.req_ready;
  assign bus.rsp_valid = !rst && !fifo_empty;
  assign pop           = bus.rsp_valid && bus.rsp_ready;
  assign push          = st_valid[LATENCY-1] && (!fifo_full || pop);
  assign bus.rsp_err   = bus.rsp_valid && head[DATA_W];
  assign bus.rsp_data  = bus.rsp_valid ? head[DATA_W-1:0] : '0;

  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_idx] <= ld_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) st_valid[i] <= 1'b0;
    end else begin
      st_valid[0] <= accept;
      for (int i = 1; i < LATENCY; i++) st_valid[i] <= st_valid[i-1];
    end
  end

  // The read samples the array before this edge's loader write lands (read-before-write).
  always_ff @(posedge clk) begin
    st_err[0]  <= req_err ? ERR : OK;
    st_data[0] <= req_err ? '0 : mem[word_off[IDX_W-1:0]];
    for (int i = 1; i < LATENCY; i++) begin
      st_err[i]  <= st_err[i-1];
      st_data[i] <= st_data[i-1];
    end
  end

  ysyx_22040175_sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({st_err[LATENCY-1], st_data[LATENCY-1]}),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );
endmodule

// File: tb/tb_ysyx_22040175_imem_resp.sv
// tb/tb_ysyx_22040175_imem_resp.sv - self-checking bench for the instruction memory responder
module tb_ysyx_22040175_imem_resp;
  localparam int LAT = 2;
  localparam int DEPTH = 4;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ld_en = 1'b0;
  logic [9:0] ld_idx = '0;
  logic [31:0] ld_data = '0;
  int cyc = 0;

  ysyx_22040175_imem_resp_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  ysyx_22040175_imem_resp dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .ld_en   (ld_en),
    .ld_idx  (ld_idx),
    .ld_data (ld_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic err; logic [31:0] data; int t; } exp_t;
  typedef struct { logic err; logic [31:0] data; int c; } log_t;

  exp_t q[$];
  log_t plog[$];
  int alog[$];
  logic [31:0] mm [1024];
  int valid_seen = 0;
  int n_chk = 0;
  int n_pass = 0;
  logic prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic prev_err = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: a request is a pending entry that becomes visible LAT edges after acceptance.
  always @(negedge clk) begin
    logic [31:0] a;
    logic e;
    logic [31:0] d;
    chk("rsp_valid", bus.rsp_valid, !rst && q.size() > 0 && q[0].t <= cyc);
    chk("req_ready", bus.req_ready, !rst && q.size() < DEPTH);
    if (rst) begin
      chk("rst_data", bus.rsp_data, 0);
      chk("rst_err", bus.rsp_err, 0);
    end else if (prev_stall) begin
      chk("stall_valid", bus.rsp_valid, 1);
      chk("stall_data", bus.rsp_data, prev_data);
      chk("stall_err", bus.rsp_err, prev_err);
    end
    if (bus.rsp_valid) valid_seen++;
    if (bus.rsp_valid && bus.rsp_ready) begin
      if (q.size() > 0) begin
        chk("rsp_data", bus.rsp_data, q[0].data);
        chk("rsp_err", bus.rsp_err, q[0].err);
        q.pop_front();
      end else begin
        chk("rsp_unexpected", 1, 0);
      end
      plog.push_back('{bus.rsp_err, bus.rsp_data, cyc});
    end
    if (bus.req_valid && bus.req_ready) begin
      a = bus.req_addr;
      e = (a[1:0] != 2'b00) || (a < BASE) || (a >= BASE + 32'd4096);
      d = e ? 32'd0 : mm[(a - BASE) / 4];
      q.push_back('{e, d, cyc + 1 + LAT});
      alog.push_back(cyc + 1);
    end
    if (ld_en) mm[ld_idx] = ld_data;
    if (rst) q.delete();
    prev_stall = !rst && bus.rsp_valid && !bus.rsp_ready;
    prev_data = bus.rsp_data;
    prev_err = bus.rsp_err;
  end

  initial begin
    logic [31:0] lit [4];
    int r;
    lit[0] = 32'h0000_0013; lit[1] = 32'h0010_0093;
    lit[2] = 32'h0020_0113; lit[3] = 32'h0030_0193;
    bus.req_valid = 1'b0;
    bus.req_addr = '0;
    bus.rsp_ready = 1'b0;

    step();
    chk("reset_req_ready", bus.req_ready, 0);
    chk("reset_rsp_valid", bus.rsp_valid, 0);
    chk("reset_rsp_data", bus.rsp_data, 0);
    for (int i = 0; i < 1024; i++) begin
      ld_en = 1'b1; ld_idx = 10'(i); ld_data = $urandom;
      step();
    end
    for (int i = 0; i < 4; i++) begin
      ld_idx = 10'(i); ld_data = lit[i];
      step();
    end
    ld_en = 1'b0; rst = 1'b0;
    step();

    // back-to-back fetch, consumer always ready
    plog.delete(); alog.delete();
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.req_valid = 1'b1; bus.req_addr = BASE + 32'(4 * i);
      step();
    end
    bus.req_valid = 1'b0;
    repeat (6) step();
    chk("t1_count", plog.size(), 4);
    if (plog.size() == 4 && alog.size() == 4) begin
      chk("t1_first_latency", plog[0].c - alog[0], 2);
      for (int i = 0; i < 4; i++) begin
        chk("t1_data", plog[i].data, lit[i]);
        chk("t1_spacing", plog[i].c - plog[0].c, i);
      end
    end

    // consumer stalled: only DEPTH accepts
    plog.delete(); alog.delete();
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.req_valid = 1'b1; bus.req_addr = BASE + 32'(4 * (i % 4));
      step();
    end
    bus.req_valid = 1'b0;
    chk("t2_accepts", alog.size(), 4);
    chk("t2_ready_full", bus.req_ready, 0);
    bus.rsp_ready = 1'b1;
    #1 chk("t2_ready_before_pop", bus.req_ready, 0);
    step();
    chk("t2_ready_after_pop", bus.req_ready, 1);
    repeat (6) step();
    chk("t2_count", plog.size(), 4);
    if (plog.size() == 4)
      for (int i = 0; i < 4; i++) chk("t2_data", plog[i].data, lit[i]);

    // error cases and recovery
    plog.delete();
    for (int i = 0; i < 4; i++) begin
      bus.req_valid = 1'b1;
      case (i)
        0: bus.req_addr = 32'h8000_0002;
        1: bus.req_addr = 32'h7FFF_FFFC;
        2: bus.req_addr = 32'h8000_1000;
        default: bus.req_addr = 32'h8000_0004;
      endcase
      step();
    end
    bus.req_valid = 1'b0;
    repeat (6) step();
    chk("t3_count", plog.size(), 4);
    if (plog.size() == 4) begin
      for (int i = 0; i < 3; i++) begin
        chk("t3_err", plog[i].err, 1);
        chk("t3_err_data", plog[i].data, 0);
      end
      chk("t3_ok_err", plog[3].err, 0);
      chk("t3_ok_data", plog[3].data, 32'h0010_0093);
    end

    // loader write colliding with a read of the same word
    plog.delete();
    ld_en = 1'b1; ld_idx = 10'd2; ld_data = 32'hDEAD_BEEF;
    bus.req_valid = 1'b1; bus.req_addr = 32'h8000_0008;
    step();
    ld_en = 1'b0;
    step();
    bus.req_valid = 1'b0;
    repeat (6) step();
    chk("t4_count", plog.size(), 2);
    if (plog.size() == 2) begin
      chk("t4_old_word", plog[0].data, 32'h0020_0113);
      chk("t4_new_word", plog[1].data, 32'hDEAD_BEEF);
    end

    // reset with work in flight
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.req_valid = 1'b1; bus.req_addr = BASE + 32'(4 * i);
      step();
    end
    bus.req_valid = 1'b0; rst = 1'b1;
    #1 chk("t5_ready_in_rst", bus.req_ready, 0);
    step();
    rst = 1'b0;
    #1 chk("t5_ready_after_rst", bus.req_ready, 1);
    plog.delete(); valid_seen = 0;
    bus.rsp_ready = 1'b1;
    repeat (12) step();
    chk("t5_no_valid", valid_seen, 0);
    bus.req_valid = 1'b1; bus.req_addr = 32'h8000_000C;
    step();
    bus.req_valid = 1'b0;
    repeat (5) step();
    chk("t5_count", plog.size(), 1);
    if (plog.size() == 1) chk("t5_data", plog[0].data, 32'h0030_0193);

    // random traffic against the reference
    plog.delete(); alog.delete();
    for (int i = 0; i < 10000; i++) begin
      r = int'($urandom_range(0, 15));
      bus.req_valid = ($urandom_range(0, 3) != 0);
      if (r == 0) bus.req_addr = $urandom;
      else if (r == 1) bus.req_addr = BASE + 32'd4096 + 32'(4 * $urandom_range(0, 7));
      else if (r == 2) bus.req_addr = BASE + 32'(4 * $urandom_range(0, 1023)) + 32'($urandom_range(1, 3));
      else bus.req_addr = BASE + 32'(4 * $urandom_range(0, 1023));
      bus.rsp_ready = ((i / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      ld_en = ($urandom_range(0, 7) == 0);
      ld_idx = 10'($urandom_range(0, 1023));
      ld_data = $urandom;
      step();
    end
    bus.req_valid = 1'b0; ld_en = 1'b0; bus.rsp_ready = 1'b1;
    repeat (10) step();
    chk("t6_drained", q.size(), 0);
    chk("t6_no_loss_dup", plog.size(), alog.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
